// File: rtl/ps_linebuffer_win.sv
// Single-line pixel buffer returning a TAPS-wide horizontal window per accepted read.
// Border handling: wrap-around by default, edge replication when PS_LINEBUF_CLAMP_EN is defined.
module ps_linebuffer_win #(
    parameter int DATA_W      = 8,
    parameter int LINE_LENGTH = 640,
    parameter int TAPS        = 3
) (
    input  logic                             i_clk,
    input  logic                             i_rstn,
    input  logic                             i_wr,
    input  logic [DATA_W-1:0]                i_wdata,
    input  logic                             i_rd,
    output logic [TAPS*DATA_W-1:0]           o_rdata,
    output logic                             o_rvalid,
    output logic                             o_sol,
    output logic                             o_eol,
    output logic [$clog2(LINE_LENGTH+1)-1:0] o_count,
    output logic                             o_full,
    output logic                             o_empty
);

    localparam int HALF = (TAPS - 1) / 2;
    localparam int AW   = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
    localparam int CW   = $clog2(LINE_LENGTH + 1);
    // Wide enough that rptr+HALF never wraps in signed arithmetic.
    localparam int IW   = $clog2(LINE_LENGTH + HALF) + 1;

    logic [DATA_W-1:0]      mem [LINE_LENGTH];
    logic [AW-1:0]          wptr;
    logic [AW-1:0]          rptr;
    logic [CW-1:0]          count;
    logic [TAPS*DATA_W-1:0] window;
    logic                   full;
    logic                   wr_ok;
    logic                   rd_ok;

    assign full    = (count == CW'(LINE_LENGTH));
    assign wr_ok   = i_wr && !full;
    assign rd_ok   = i_rd && (count > CW'(HALF));
    assign o_count = count;
    assign o_full  = full;
    assign o_empty = (count == '0);

    for (genvar k = 0; k < TAPS; k++) begin : g_tap
        localparam int OFS = k - HALF;
        logic signed [IW-1:0] pos;
        logic [AW-1:0]        idx;

        assign pos = $signed({{(IW-AW){1'b0}}, rptr}) + IW'(OFS);

`ifdef PS_LINEBUF_CLAMP_EN
        always_comb begin
            if (pos < IW'(0))
                idx = '0;
            else if (pos > IW'(LINE_LENGTH - 1))
                idx = AW'(LINE_LENGTH - 1);
            else
                idx = pos[AW-1:0];
        end
`else
        always_comb begin
            if (pos < IW'(0))
                idx = AW'(pos + IW'(LINE_LENGTH));
            else if (pos > IW'(LINE_LENGTH - 1))
                idx = AW'(pos - IW'(LINE_LENGTH));
            else
                idx = pos[AW-1:0];
        end
`endif

        // Tap k=0 is the leftmost pixel and lands in the MSB slice.
        assign window[(TAPS-1-k)*DATA_W +: DATA_W] = mem[idx];
    end

    always_ff @(posedge i_clk) begin
        if (i_rstn && wr_ok)
            mem[wptr] <= i_wdata;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            o_rdata  <= '0;
            o_rvalid <= 1'b0;
            o_sol    <= 1'b0;
            o_eol    <= 1'b0;
        end else begin
            o_rvalid <= rd_ok;
            o_sol    <= rd_ok && (rptr == '0);
            o_eol    <= rd_ok && (rptr == AW'(LINE_LENGTH - 1));
            if (rd_ok) begin
                o_rdata <= window;
                rptr    <= (rptr == AW'(LINE_LENGTH - 1)) ? '0 : rptr + AW'(1);
            end
            if (wr_ok)
                wptr <= (wptr == AW'(LINE_LENGTH - 1)) ? '0 : wptr + AW'(1);
            if (wr_ok && !rd_ok)
                count <= count + CW'(1);
            else if (rd_ok && !wr_ok)
                count <= count - CW'(1);
        end
    end

endmodule

// File: tb/tb_ps_linebuffer_win.sv
// Scoreboard bench for ps_linebuffer_win: default 640x3x8 instance plus a 100x5x10 instance.
// Expectations follow PS_LINEBUF_CLAMP_EN when it is defined.
module tb_ps_linebuffer_win;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, wr, rd;
    logic [7:0]  wdata;
    logic [23:0] rdata;
    logic        rvalid, sol, eol, full, empty;
    logic [9:0]  count;

    logic        rstn5, wr5, rd5;
    logic [9:0]  wdata5;
    logic [49:0] rdata5;
    logic        rvalid5, sol5, eol5, full5, empty5;
    logic [6:0]  count5;

    ps_linebuffer_win #(.DATA_W(8), .LINE_LENGTH(640), .TAPS(3)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_wr(wr), .i_wdata(wdata), .i_rd(rd),
        .o_rdata(rdata), .o_rvalid(rvalid), .o_sol(sol), .o_eol(eol),
        .o_count(count), .o_full(full), .o_empty(empty)
    );

    ps_linebuffer_win #(.DATA_W(10), .LINE_LENGTH(100), .TAPS(5)) dut5 (
        .i_clk(clk), .i_rstn(rstn5), .i_wr(wr5), .i_wdata(wdata5), .i_rd(rd5),
        .o_rdata(rdata5), .o_rvalid(rvalid5), .o_sol(sol5), .o_eol(eol5),
        .o_count(count5), .o_full(full5), .o_empty(empty5)
    );

    typedef struct {
        int          due;
        logic [23:0] data;
        logic        sol;
        logic        eol;
    } exp_t;

    exp_t       q[$];
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    logic [7:0] m_mem [640];
    int         m_wptr, m_rptr, m_count;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] model_win(input int c);
        logic [23:0] w;
        int x;
        w = '0;
        for (int k = -1; k <= 1; k++) begin
            x = c + k;
`ifdef PS_LINEBUF_CLAMP_EN
            if (x < 0) x = 0;
            if (x > 639) x = 639;
`else
            if (x < 0) x = x + 640;
            if (x > 639) x = x - 640;
`endif
            w[(1-k)*8 +: 8] = m_mem[x];
        end
        return w;
    endfunction

    // One clock of stimulus; the model decides acceptance from pre-edge state.
    task automatic drive(input logic w, input logic [7:0] wd, input logic r);
        logic wok, rok;
        exp_t e;
        wr = w; wdata = wd; rd = r;
        wok = w && (m_count != 640);
        rok = r && (m_count > 1);
        if (rok) begin
            e.due  = cyc + 1;
            e.data = model_win(m_rptr);
            e.sol  = (m_rptr == 0);
            e.eol  = (m_rptr == 639);
            q.push_back(e);
            m_rptr = (m_rptr == 639) ? 0 : m_rptr + 1;
        end
        if (wok) begin
            m_mem[m_wptr] = wd;
            m_wptr = (m_wptr == 639) ? 0 : m_wptr + 1;
        end
        m_count = m_count + (wok ? 1 : 0) - (rok ? 1 : 0);
        @(posedge clk); #1;
        wr = 1'b0; rd = 1'b0;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due == cyc) begin
            checks++;
            if (rvalid !== 1'b1 || rdata !== q[0].data || sol !== q[0].sol || eol !== q[0].eol) begin
                failures++;
                $display("FAIL scoreboard_window cyc=%0d got v=%b d=%h sol=%b eol=%b, need v=1 d=%h sol=%b eol=%b",
                         cyc, rvalid, rdata, sol, eol, q[0].data, q[0].sol, q[0].eol);
            end
            void'(q.pop_front());
        end else if (rvalid !== 1'b0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rvalid cyc=%0d got %b need 0", cyc, rvalid);
        end
    end

    task automatic do_reset();
        rstn = 1'b0; wr = 1'b0; rd = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b1;
        m_wptr = 0; m_rptr = 0; m_count = 0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; rd = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rvalid !== 1'b0 || rdata !== 24'h0 || count !== 10'd0 || empty !== 1'b1 || full !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got v=%b d=%h cnt=%0d e=%b f=%b need 0 0 0 1 0", rvalid, rdata, count, empty, full);
        end
        rd = 1'b0;
        do_reset();
        drive(1'b0, 8'h00, 1'b1);
        checks++;
        if (rvalid !== 1'b0 || count !== 10'd0) begin
            failures++;
            $display("FAIL read_when_empty got v=%b cnt=%0d need v=0 cnt=0", rvalid, count);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 10; i++) drive(1'b1, i[7:0], 1'b0);
        checks++;
        if (count !== 10'd10 || empty !== 1'b0) begin
            failures++;
            $display("FAIL count_after_10 got cnt=%0d e=%b need cnt=10 e=0", count, empty);
        end
        for (int i = 10; i < 640; i++) drive(1'b1, i[7:0], 1'b0);
        checks++;
        if (full !== 1'b1 || count !== 10'd640) begin
            failures++;
            $display("FAIL full_flag got f=%b cnt=%0d need f=1 cnt=640", full, count);
        end
        drive(1'b1, 8'hAA, 1'b0);
        checks++;
        if (full !== 1'b1 || count !== 10'd640) begin
            failures++;
            $display("FAIL write_when_full got f=%b cnt=%0d need f=1 cnt=640", full, count);
        end
    endtask

    task automatic test_borders();
`ifdef PS_LINEBUF_CLAMP_EN
        logic [23:0] first = 24'h000001;
        logic [23:0] last  = 24'h7E7F7F;
`else
        logic [23:0] first = 24'h7F0001;
        logic [23:0] last  = 24'h7E7F00;
`endif
        drive(1'b0, 8'h00, 1'b1);
        checks++;
        if (rvalid !== 1'b1 || rdata !== first || sol !== 1'b1 || eol !== 1'b0) begin
            failures++;
            $display("FAIL col0_window got v=%b d=%h sol=%b eol=%b need v=1 d=%h sol=1 eol=0", rvalid, rdata, sol, eol, first);
        end
        for (int i = 1; i < 638; i++) drive(1'b0, 8'h00, 1'b1);
        // Start of the next line (value 0x00) lands at address 0 while col 638 is read.
        drive(1'b1, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        checks++;
        if (rvalid !== 1'b1 || rdata !== last || eol !== 1'b1 || sol !== 1'b0) begin
            failures++;
            $display("FAIL col639_window got v=%b d=%h sol=%b eol=%b need v=1 d=%h sol=0 eol=1", rvalid, rdata, sol, eol, last);
        end
        drive(1'b0, 8'h00, 1'b1);
        checks++;
        if (rvalid !== 1'b0 || count !== 10'd1) begin
            failures++;
            $display("FAIL read_count_le_half got v=%b cnt=%0d need v=0 cnt=1", rvalid, count);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1'b1, 8'h40, 1'b0);
        drive(1'b1, 8'h41, 1'b0);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 8'(8'h42 + i), 1'b1);
            checks++;
            if (count !== 10'd2 || rvalid !== 1'b1 || rdata[15:8] !== 8'(8'h40 + i)) begin
                failures++;
                $display("FAIL stream_step%0d got cnt=%0d v=%b centre=%h need cnt=2 v=1 centre=%h",
                         i, count, rvalid, rdata[15:8], 8'(8'h40 + i));
            end
        end
    endtask

    task automatic test_taps5();
`ifdef PS_LINEBUF_CLAMP_EN
        logic [49:0] exp_win = {10'h101, 10'h101, 10'h101, 10'h102, 10'h103};
`else
        logic [49:0] exp_win = {10'h262, 10'h263, 10'h101, 10'h102, 10'h103};
`endif
        rstn5 = 1'b1;
        for (int i = 0; i < 100; i++) begin
            wr5 = 1'b1; wdata5 = 10'(10'h200 + i);
            @(posedge clk); #1;
        end
        wr5 = 1'b0;
        checks++;
        if (full5 !== 1'b1 || count5 !== 7'd100) begin
            failures++;
            $display("FAIL t5_full got f=%b cnt=%0d need f=1 cnt=100", full5, count5);
        end
        rstn5 = 1'b0;
        @(posedge clk); #1;
        rstn5 = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            wr5 = 1'b1; wdata5 = 10'(10'h100 + i);
            @(posedge clk); #1;
        end
        wr5 = 1'b0; rd5 = 1'b1;
        @(posedge clk); #1;
        rd5 = 1'b0;
        checks++;
        if (rvalid5 !== 1'b0 || count5 !== 7'd2) begin
            failures++;
            $display("FAIL t5_read_cnt2 got v=%b cnt=%0d need v=0 cnt=2", rvalid5, count5);
        end
        wr5 = 1'b1; wdata5 = 10'h103;
        @(posedge clk); #1;
        wr5 = 1'b0; rd5 = 1'b1;
        @(posedge clk); #1;
        rd5 = 1'b0;
        checks++;
        if (rvalid5 !== 1'b1 || rdata5 !== exp_win || sol5 !== 1'b1 || count5 !== 7'd2) begin
            failures++;
            $display("FAIL t5_read_cnt3 got v=%b d=%h sol=%b cnt=%0d need v=1 d=%h sol=1 cnt=2",
                     rvalid5, rdata5, sol5, count5, exp_win);
        end
        wr5 = 1'b1; wdata5 = 10'h104;
        @(posedge clk); #1;
        wr5 = 1'b0; rstn5 = 1'b0; rd5 = 1'b1;
        @(posedge clk); #1;
        rd5 = 1'b0;
        checks++;
        if (count5 !== 7'd0 || rvalid5 !== 1'b0 || rdata5 !== 50'h0 || empty5 !== 1'b1) begin
            failures++;
            $display("FAIL t5_mid_reset got cnt=%0d v=%b d=%h e=%b need 0 0 0 1", count5, rvalid5, rdata5, empty5);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; wr = 1'b0; rd = 1'b0; wdata = '0;
        rstn5 = 1'b0; wr5 = 1'b0; rd5 = 1'b0; wdata5 = '0;
        m_wptr = 0; m_rptr = 0; m_count = 0;
        test_reset();
        test_fill();
        test_borders();
        test_back_to_back();
        test_taps5();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending need 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps_linebuffer_win.md
Name: ps_linebuffer_win

Overview:
Parametrised line buffer for the pixel-stream (ps_) pipeline. It stores one video line of DATA_W-bit pixels and returns a horizontal window of TAPS pixels per accepted read. Unlike the fixed 3-tap buffer, it has a configurable tap count and pixel width, occupancy tracking with full/empty flags, a read-valid strobe and line-position flags. It sits between the pixel source and the k×k convolution/kernel stages; one instance per kernel row.

Parameters:
DATA_W, 8, pixel width in bits
LINE_LENGTH, 640, pixels per line; memory depth; must be ≥ TAPS
TAPS, 3, window width; odd, ≥ 1; HALF = (TAPS-1)/2

Ports:
i_clk  in  1  clock; all logic on rising edge
i_rstn  in  1  reset, synchronous, active-low
i_wr  in  1  write request
i_wdata  in  DATA_W  write pixel
i_rd  in  1  read request
o_rdata  out  TAPS*DATA_W  window, registered; MSB slice = leftmost pixel (col-HALF), LSB slice = rightmost (col+HALF)
o_rvalid  out  1  o_rdata updated this cycle
o_sol  out  1  with o_rvalid: centre column = 0
o_eol  out  1  with o_rvalid: centre column = LINE_LENGTH-1
o_count  out  clog2(LINE_LENGTH+1)  stored, unread pixels
o_full  out  1  o_count == LINE_LENGTH
o_empty  out  1  o_count == 0

Behaviour:
- Reset (i_rstn=0 at edge): wptr=0, rptr=0, count=0, o_rdata=0, o_rvalid=0, o_sol=0, o_eol=0. Memory contents are not cleared. Reset mid-line discards the partial line.
- Write accepted when i_wr && !o_full: mem[wptr] <= i_wdata; wptr advances, wrapping LINE_LENGTH-1 → 0. A write while full is dropped; wptr and count are unchanged.
- Read accepted when i_rd && (o_count > HALF). This guarantees the right-hand taps are written. Any other read is ignored; rptr is unchanged and o_rvalid=0 next cycle.
- On an accepted read at centre column c=rptr:
  - Window tap k (k = -HALF..+HALF) = mem[idx(c+k)].
  - Memory is read combinationally, then the window is registered. Latency is one cycle: o_rdata, o_rvalid=1, o_sol=(c==0) and o_eol=(c==LINE_LENGTH-1) appear the cycle after.
  - rptr advances, wrapping LINE_LENGTH-1 → 0.
- When no read is accepted: o_rdata holds its previous value; o_rvalid, o_sol and o_eol are 0.
- Count update: +1 on an accepted write only; -1 on an accepted read only; unchanged when both or neither are accepted.
- Full and simultaneous read: the read is accepted first, but the write is still dropped. Full is evaluated on the pre-edge count.
- Read-during-write to the same address: the read returns pre-write memory contents.
- Left taps (k<0) return whatever the memory currently holds at those addresses (already consumed pixels). This is valid because the memory is never cleared.
- Index arithmetic is done at clog2(LINE_LENGTH)+1 bits, signed, to avoid modular aliasing. LINE_LENGTH need not be a power of two.
- idx() is defined by the border mode (see Optional Feature).

Optional Feature:
Macro: PS_LINEBUF_CLAMP_EN
- Defined: idx(x) = 0 if x<0; LINE_LENGTH-1 if x>LINE_LENGTH-1; else x. Border pixels are replicated at line edges (col 0 left taps = pixel 0; col LINE_LENGTH-1 right taps = last pixel).
- Undefined: idx(x) = x mod LINE_LENGTH (wrap-around). This is the legacy behaviour: edge taps take pixels from the opposite end of the line.
- Neither mode changes latency or handshake.

Test Plan:
1. Reset then write 0..9 (LINE_LENGTH=640, TAPS=3). o_count=10 and o_empty=0. A read before any write is ignored (o_rvalid stays 0).
2. After writing 640 pixels with value=col[7:0]: o_full=1. An extra write of 0xAA is dropped, and mem[0] still holds 0x00.
3. Clamp mode, line full with pixels 0..639 (mod 256). The first read gives o_rdata={0x00,0x00,0x01}, o_sol=1. The read at col 639 gives {0x7E,0x7F,0x7F}, o_eol=1.
4. Same as 3 with no macro: col 0 gives {0x7F,0x00,0x01}; col 639 gives {0x7E,0x7F,0x00}.
5. Streaming: write and read asserted every cycle after 2 pixels primed. o_count stays 2, o_rvalid is high every cycle one cycle after each read, and centre pixels appear in order.
6. TAPS=5, DATA_W=10, LINE_LENGTH=100:
   - Read with o_count=2: rejected.
   - Read with o_count=3: accepted; 50-bit window appears one cycle later.
   - Assert i_rstn=0 mid-line: o_count=0, o_rvalid=0, o_rdata=0 the next cycle.
